// File: rtl/dglk_pkg.sv
// Shared definitions for the dual-port block-RAM wrapper: read-during-write
// encodings, control FSM states and the byte-lane count helper.
package dglk_pkg;

    localparam int RDW_OLD = 0;
    localparam int RDW_NEW = 1;

    typedef enum logic {
        CLR = 1'b0,
        RUN = 1'b1
    } state_t;

    function automatic int nb_of(input int dw);
        return (dw + 7) / 8;
    endfunction

endpackage

// File: rtl/dglk_bram_core.sv
// Simple dual-port storage array: per-lane write enables, registered read,
// written in the shape synthesis maps onto block RAM.
module dglk_bram_core
    import dglk_pkg::*;
#(
    parameter int DW = 40,
    parameter int AW = 16,
    localparam int NB = nb_of(DW)
) (
    input  logic          clk,
    input  logic [NB-1:0] we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    localparam int LEN = 2 ** AW;

    logic [DW-1:0] mem [LEN];

    // NOTE: the array and its read register carry no reset; a reset would stop block-RAM inference.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NB - 1; k++) begin
            if (we[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
        end
        if (we[NB-1]) mem[waddr][DW-1:8*(NB-1)] <= wdata[DW-1:8*(NB-1)];
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/dglk_bram_dp.sv
// Dual-port RAM wrapper: post-reset zero-fill sweep, same-address bypass merge
// and a one- or two-stage read pipeline around dglk_bram_core.
module dglk_bram_dp
    import dglk_pkg::*;
#(
    parameter int DW       = 40,
    parameter int AW       = 16,
    parameter int RD_LAT   = 1,
    parameter int RDW_MODE = RDW_OLD,
    parameter int INIT_CLR = 1,
    localparam int NB      = nb_of(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          w_ena,
    input  logic [NB-1:0] w_be,
    input  logic [AW-1:0] w_addr,
    input  logic [DW-1:0] w_data,
    input  logic          r_ena,
    input  logic [AW-1:0] r_addr,
    output logic [DW-1:0] r_data,
    output logic          r_vld,
    output logic          busy
);

    localparam int          LEN       = 2 ** AW;
    localparam logic [AW:0] LAST      = (AW + 1)'(LEN - 1);
    localparam state_t      RST_STATE = (INIT_CLR != 0) ? CLR : RUN;

    state_t        state;
    logic [AW:0]   cnt;
    logic [NB-1:0] core_we;
    logic [AW-1:0] core_waddr;
    logic [DW-1:0] core_wdata;
    logic [DW-1:0] core_rdata;
    logic          rd_fire;
    logic          wr_user;
    logic          v1;
    logic          have_data;
    logic          byp_hit;
    logic [NB-1:0] byp_be;
    logic [DW-1:0] byp_data;
    logic [DW-1:0] merged;

    // NOTE: sequential state uses non-blocking assignments only; combinational logic uses blocking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RST_STATE;
            cnt   <= '0;
            busy  <= (INIT_CLR != 0);
        end else if (state == CLR) begin
            if (cnt == LAST) begin
                state <= RUN;
                busy  <= 1'b0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign rd_fire = r_ena && (state == RUN);
    assign wr_user = w_ena && (state == RUN);

    // NOTE: every output gets a default first so no path infers a latch.
    always_comb begin
        core_we    = '0;
        core_waddr = w_addr;
        core_wdata = w_data;
        if (state == CLR) begin
            core_we    = '1;
            core_waddr = cnt[AW-1:0];
            core_wdata = '0;
        end else if (w_ena) begin
            core_we = w_be;
        end
    end

    dglk_bram_core #(.DW(DW), .AW(AW)) u_core (
        .clk   (clk),
        .we    (core_we),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (rd_fire),
        .raddr (r_addr),
        .rdata (core_rdata)
    );

    // The core always returns pre-write data; the write lanes are captured so
    // new-data mode can overlay them one cycle later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1        <= 1'b0;
            have_data <= 1'b0;
            byp_hit   <= 1'b0;
            byp_be    <= '0;
            byp_data  <= '0;
        end else begin
            v1 <= rd_fire;
            if (rd_fire) begin
                have_data <= 1'b1;
                byp_hit   <= (RDW_MODE == RDW_NEW) && wr_user && (w_addr == r_addr);
                byp_be    <= w_be;
                byp_data  <= w_data;
            end
        end
    end

    always_comb begin
        merged = core_rdata;
        for (int i = 0; i < DW; i++) begin
            if (byp_hit && byp_be[i/8]) merged[i] = byp_data[i];
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_data <= '0;
                r_vld  <= 1'b0;
            end else begin
                r_vld <= v1;
                if (v1) r_data <= merged;
            end
        end
    end else begin : g_lat1
        // The array register has no reset, so mask it until the first read lands.
        assign r_vld  = v1;
        assign r_data = have_data ? merged : '0;
    end

endmodule

// File: tb/tb_dglk_bram_dp.sv
// Randomised and directed bench for dglk_bram_dp: one instance with RD_LAT=1/old-data,
// one with RD_LAT=2/new-data, both compared against a queue-based memory model.
module tb_dglk_bram_dp;

    localparam int DW  = 40;
    localparam int AW  = 4;
    localparam int NB  = 5;
    localparam int LEN = 16;

    logic          clk    = 1'b0;
    logic          rst_n  = 1'b1;
    logic          w_ena  = 1'b0;
    logic [NB-1:0] w_be   = '0;
    logic [AW-1:0] w_addr = '0;
    logic [DW-1:0] w_data = '0;
    logic          r_ena  = 1'b0;
    logic [AW-1:0] r_addr = '0;
    logic [DW-1:0] r_data_a, r_data_b;
    logic          r_vld_a, r_vld_b, busy_a, busy_b;

    always #5 clk = ~clk;

    dglk_bram_dp #(.DW(DW), .AW(AW), .RD_LAT(1), .RDW_MODE(0), .INIT_CLR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .w_ena(w_ena), .w_be(w_be), .w_addr(w_addr),
        .w_data(w_data), .r_ena(r_ena), .r_addr(r_addr), .r_data(r_data_a),
        .r_vld(r_vld_a), .busy(busy_a)
    );

    dglk_bram_dp #(.DW(DW), .AW(AW), .RD_LAT(2), .RDW_MODE(1), .INIT_CLR(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .w_ena(w_ena), .w_be(w_be), .w_addr(w_addr),
        .w_data(w_data), .r_ena(r_ena), .r_addr(r_addr), .r_data(r_data_b),
        .r_vld(r_vld_b), .busy(busy_b)
    );

    typedef struct {
        int            due;
        logic [DW-1:0] data;
    } rd_t;

    rd_t           q_a[$];
    rd_t           q_b[$];
    logic [DW-1:0] ref_mem [LEN];
    logic [DW-1:0] last_a = '0;
    logic [DW-1:0] last_b = '0;
    int            sweep_left  = 0;
    int            edge_n      = 0;
    int            n_checks    = 0;
    int            n_fail      = 0;
    int            vld_b_cnt   = 0;
    int            first_vld_b = -1;

    function automatic logic [DW-1:0] lane_merge(input logic [DW-1:0] base,
                                                 input logic [DW-1:0] nw,
                                                 input logic [NB-1:0] be);
        logic [DW-1:0] r;
        r = base;
        for (int k = 0; k < NB; k++) begin
            if (be[k]) r[8*k +: 8] = nw[8*k +: 8];
        end
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic step();
        rd_t  e;
        logic exp_vld;
        @(posedge clk);
        #1;
        edge_n++;
        if (sweep_left > 0) begin
            ref_mem[LEN-sweep_left] = '0;
            sweep_left--;
        end else begin
            if (r_ena) begin
                e.data = ref_mem[r_addr];
                e.due  = edge_n;
                q_a.push_back(e);
                if (w_ena && (w_addr == r_addr)) e.data = lane_merge(e.data, w_data, w_be);
                e.due = edge_n + 1;
                q_b.push_back(e);
            end
            if (w_ena) ref_mem[w_addr] = lane_merge(ref_mem[w_addr], w_data, w_be);
        end

        exp_vld = (q_a.size() > 0) && (q_a[0].due == edge_n);
        if (exp_vld) begin
            e = q_a.pop_front();
            last_a = e.data;
        end
        check("vld_a", 64'(r_vld_a), 64'(exp_vld));
        check("data_a", 64'(r_data_a), 64'(last_a));

        exp_vld = (q_b.size() > 0) && (q_b[0].due == edge_n);
        if (exp_vld) begin
            e = q_b.pop_front();
            last_b = e.data;
        end
        check("vld_b", 64'(r_vld_b), 64'(exp_vld));
        check("data_b", 64'(r_data_b), 64'(last_b));

        check("busy_a", 64'(busy_a), 64'(sweep_left > 0));
        check("busy_b", 64'(busy_b), 64'(sweep_left > 0));

        if (r_vld_b) begin
            vld_b_cnt++;
            if (first_vld_b < 0) first_vld_b = edge_n;
        end
    endtask

    task automatic cyc(input logic we, input logic [NB-1:0] be, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic re, input logic [AW-1:0] ra);
        w_ena  = we;
        w_be   = be;
        w_addr = wa;
        w_data = wd;
        r_ena  = re;
        r_addr = ra;
        step();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0);
    endtask

    task automatic do_reset();
        w_ena = 1'b0;
        r_ena = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rst_vld_a", 64'(r_vld_a), 64'(0));
        check("rst_vld_b", 64'(r_vld_b), 64'(0));
        check("rst_data_a", 64'(r_data_a), 64'(0));
        check("rst_data_b", 64'(r_data_b), 64'(0));
        check("rst_busy_a", 64'(busy_a), 64'(1));
        check("rst_busy_b", 64'(busy_b), 64'(1));
        q_a.delete();
        q_b.delete();
        last_a     = '0;
        last_b     = '0;
        sweep_left = LEN;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    task automatic sweep_wait(input int already);
        int n;
        n = already;
        while (busy_a && n < 40) begin
            idle(1);
            n++;
        end
        check("busy_len", 64'(n), 64'(LEN));
    endtask

    task automatic read_all();
        int issue_edge;
        vld_b_cnt   = 0;
        first_vld_b = -1;
        issue_edge  = edge_n + 1;
        for (int a = 0; a < LEN; a++) cyc(1'b0, '0, '0, '0, 1'b1, AW'(a));
        idle(3);
        check("burst_cnt_b", 64'(vld_b_cnt), 64'(LEN));
        check("burst_start_b", 64'(first_vld_b), 64'(issue_edge + 1));
    endtask

    initial begin
        for (int i = 0; i < LEN; i++) ref_mem[i] = '0;
        #1;
        do_reset();

        // Blocked user traffic during the first sweep.
        idle(3);
        cyc(1'b1, 5'b11111, 4'd2, 40'h12, 1'b1, 4'd2);
        sweep_wait(4);
        read_all();

        // Partial-lane write merge.
        cyc(1'b1, 5'b11111, 4'd3, 40'hAA_BBCC_DDEE, 1'b0, '0);
        cyc(1'b1, 5'b00101, 4'd3, 40'h11_2233_4455, 1'b0, '0);
        cyc(1'b0, '0, '0, '0, 1'b1, 4'd3);
        idle(3);
        check("rmw_a", 64'(r_data_a), 64'(40'hAA_BB33_DD55));
        check("rmw_b", 64'(r_data_b), 64'(40'hAA_BB33_DD55));

        // Same-address read during write.
        cyc(1'b1, 5'b11111, 4'd7, 40'h0, 1'b0, '0);
        cyc(1'b1, 5'b11111, 4'd7, 40'hFF_FFFF_FFFF, 1'b1, 4'd7);
        idle(3);
        check("rdw_old", 64'(r_data_a), 64'(40'h0));
        check("rdw_new", 64'(r_data_b), 64'(40'hFF_FFFF_FFFF));

        for (int i = 0; i < 400; i++) begin
            cyc(1'($urandom_range(0, 1)), NB'($urandom()), AW'($urandom_range(0, LEN-1)),
                DW'({$urandom(), $urandom()}), 1'($urandom_range(0, 1)),
                AW'($urandom_range(0, LEN-1)));
        end

        // Reset with reads in flight, then reset again at sweep cycle 9.
        cyc(1'b0, '0, '0, '0, 1'b1, 4'd5);
        cyc(1'b0, '0, '0, '0, 1'b1, 4'd6);
        do_reset();
        idle(9);
        do_reset();
        sweep_wait(0);
        read_all();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dglk_bram_dp.md
DGLK_BRAM_DP -- requirements
Module: dglk_bram_dp

Interface
REQ-001 The block SHALL accept these parameters, one per line:
- DW, 40, data width in bits.
- AW, 16, address width; depth LEN = 2**AW.
- RD_LAT, 1, read latency in cycles; legal values are 1 and 2.
- RDW_MODE, 0, same-address read-during-write: 0 returns old data, 1 returns new data.
- INIT_CLR, 1, 1 enables a zero-fill sweep of the whole memory after reset.
REQ-002 Ports, one per line (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- w_ena  in  1  write strobe.
- w_be  in  NB  byte-lane enables, NB = ceil(DW/8).
- w_addr  in  AW  write address.
- w_data  in  DW  write data.
- r_ena  in  1  read strobe.
- r_addr  in  AW  read address.
- r_data  out  DW  read data.
- r_vld  out  1  r_data updated this cycle.
- busy  out  1  init sweep in progress.

Function
REQ-003 Lane k SHALL cover bits [8k+7:8k]; the top lane SHALL cover only the remaining DW-8(NB-1) bits.
REQ-004 A write with w_ena=1 and busy=0 SHALL update only the lanes where w_be is set, at the next clk edge.
REQ-005 A read with r_ena=1 and busy=0 SHALL present ram[r_addr] on r_data with r_vld=1 exactly RD_LAT cycles later.
REQ-006 When RD_LAT=2, an output register SHALL follow the array register, and back-to-back reads SHALL sustain one result per cycle.
REQ-007 r_data SHALL hold its last value when no read completes; r_vld SHALL be a one-cycle pulse per read.
REQ-008 Same-cycle read and write to the same address SHALL behave as follows:
- RDW_MODE=0: return the pre-write word.
- RDW_MODE=1: return the pre-write word merged with w_data on the enabled lanes.
REQ-009 Different-address simultaneous read and write SHALL proceed independently without stalls.
REQ-010 The control FSM SHALL have two states, CLR and RUN.
REQ-011 On rst_n release, the FSM SHALL enter CLR if INIT_CLR=1, otherwise RUN.
REQ-012 In CLR the block SHALL:
- write zero to address cnt, with all lanes enabled, each cycle;
- increment cnt from 0;
- assert busy.
REQ-013 CLR SHALL transition to RUN after writing address LEN-1, so the sweep lasts LEN cycles; busy SHALL deassert in the first RUN cycle.
REQ-014 While busy=1, user w_ena and r_ena SHALL be ignored; no r_vld SHALL result from them.
REQ-015 Reads issued in the last CLR cycle SHALL be dropped.
REQ-016 The sweep counter SHALL be AW+1 bits wide so that the terminal compare does not wrap.

Reset
REQ-017 rst_n low SHALL asynchronously force r_data=0, r_vld=0, the read pipeline valids to 0 and cnt=0.
REQ-018 rst_n low SHALL asynchronously force busy=INIT_CLR and the FSM state to CLR if INIT_CLR=1, else RUN.
REQ-019 Memory contents SHALL NOT be reset; only the CLR sweep clears them.
REQ-020 Reset asserted mid-sweep SHALL restart the sweep from address 0 after release.
REQ-021 Reset asserted mid-read SHALL discard in-flight reads.

Structure
REQ-022 A shared package dglk_pkg SHALL hold:
- the RDW_MODE encodings RDW_OLD=0 and RDW_NEW=1;
- the FSM state type (CLR, RUN);
- a function computing NB from DW.
REQ-023 The storage array SHALL be one sub-module, dglk_bram_core, that:
- contains no reset;
- has a per-lane write enable and a registered read;
- is inferable as block RAM.
REQ-024 The FSM, bypass merge and output pipeline SHALL reside in dglk_bram_dp.

Verification
REQ-025 The bench SHALL use DW=40, AW=4 and cover these directed scenarios:
- INIT_CLR=1, release rst_n -> busy high for exactly 16 cycles; a subsequent read of every address returns 0.
- Write 0xAA_BBCC_DDEE to address 3 with w_be=5'b11111, then write 0x11_2233_4455 with w_be=5'b00101 -> a read of address 3 returns 0xAA_BB33_DD55.
- RD_LAT=2, reads of addresses 0..15 on consecutive cycles -> r_vld high 16 consecutive cycles, starting 2 cycles after the first r_ena, with data in address order.
- Address 7 holds 0x0; same-cycle write of 0xFF_FFFF_FFFF (all lanes) and read of address 7 -> RDW_MODE=0 returns 0x0, RDW_MODE=1 returns 0xFF_FFFF_FFFF.
- Assert rst_n low at sweep cycle 9 -> r_vld=0 immediately; after release busy lasts 16 full cycles.
- While busy, pulse w_ena to address 2 with data 0x12 and pulse r_ena -> no r_vld; address 2 reads 0 after the sweep.
